// File: rtl/trace_dump_engine.sv
// trace_dump_engine: walks one channel's circular capture buffer oldest-to-newest, corrects each sample and streams it out as bytes
module trace_dump_engine #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dump_req,
    input  logic [CH_W-1:0]          dump_chan,
    input  logic                     raw_mode,
    input  logic [DATA_W-1:0]        offset,
    input  logic [7:0]               gain,
    input  logic [ADDR_W-1:0]        trace_end,
    input  logic                     abort,
    output logic                     ram_en,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [NUM_CH*DATA_W-1:0] ram_rdata,
    output logic [7:0]               tx_data,
    output logic                     trmt,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     dump_done,
    output logic                     err
);
    localparam int BYTES = (DATA_W + 7) / 8;
    localparam int SW = BYTES * 8;
    localparam int PW = DATA_W + 1;
    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, WAIT} state_t;
    state_t state, nxt;
    logic [ADDR_W-1:0] addr, addr_n, cnt, cnt_n;
    logic [CH_W-1:0] chan, chan_n;
    logic raw, raw_n, fin, chan_ok;
    logic [DATA_W-1:0] off, off_n, rd, sat, res;
    logic [7:0] gain_r, gain_n;
    logic [SW-1:0] sh, sh_n;
    logic [1:0] bidx, bidx_n;
    logic signed [DATA_W+1:0] sum;
    logic [DATA_W+7:0] prod;
    logic [DATA_W:0] scaled;

    assign chan_ok = int'(dump_chan) < NUM_CH;
    assign rd = ram_rdata[chan*DATA_W +: DATA_W];
    assign sum = $signed({2'b00, rd}) + $signed({{2{off[DATA_W-1]}}, off});
    assign sat = sum[DATA_W+1] ? '0 : sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    assign prod = {8'd0, sat} * {{DATA_W{1'b0}}, gain_r};
    assign scaled = PW'(prod >> 7);
    assign res = raw ? rd : scaled[DATA_W] ? '1 : scaled[DATA_W-1:0];

    always_comb begin
        nxt = state;
        addr_n = addr;
        cnt_n = cnt;
        chan_n = chan;
        raw_n = raw;
        off_n = off;
        gain_n = gain_r;
        sh_n = sh;
        bidx_n = bidx;
        fin = 1'b0;
        if (state != IDLE && abort)
            nxt = IDLE;
        else
            case (state)
                IDLE: if (dump_req && chan_ok) begin
                    nxt = RD;
                    chan_n = dump_chan;
                    raw_n = raw_mode;
                    off_n = offset;
                    gain_n = gain;
                    addr_n = trace_end + 1'b1;
                    cnt_n = '0;
                end
                RD: nxt = CAP;
                CAP: begin
                    nxt = SEND;
                    sh_n = SW'(res);
                    bidx_n = 2'(BYTES - 1);
                end
                SEND: nxt = WAIT;
                WAIT: if (tx_done) begin
                    if (bidx != 2'd0) begin
                        nxt = SEND;
                        bidx_n = bidx - 2'd1;
                        sh_n = sh << 8;
                    end else if (&cnt) begin
                        nxt = IDLE;
                        fin = 1'b1;
                    end else begin
                        nxt = RD;
                        addr_n = addr + 1'b1;
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: nxt = IDLE;
            endcase
    end

    // outputs are registered from the next-state values so they line up with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            cnt <= '0;
            chan <= '0;
            raw <= 1'b0;
            off <= '0;
            gain_r <= '0;
            sh <= '0;
            bidx <= '0;
            ram_en <= 1'b0;
            ram_addr <= '0;
            tx_data <= '0;
            trmt <= 1'b0;
            busy <= 1'b0;
            dump_done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= nxt;
            addr <= addr_n;
            cnt <= cnt_n;
            chan <= chan_n;
            raw <= raw_n;
            off <= off_n;
            gain_r <= gain_n;
            sh <= sh_n;
            bidx <= bidx_n;
            ram_en <= nxt == RD;
            ram_addr <= nxt == RD ? addr_n : ram_addr;
            tx_data <= nxt == SEND ? sh_n[SW-1 -: 8] : tx_data;
            trmt <= nxt == SEND;
            busy <= nxt != IDLE;
            dump_done <= fin;
            err <= state == IDLE && dump_req && !chan_ok;
        end
    end
endmodule

// File: tb/tb_trace_dump_engine.sv
// tb_trace_dump_engine: randomized and directed dumps on an 8-bit and a 12-bit engine checked against an arithmetic model
module tb_trace_dump_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel = 1'b0, dump_req = 1'b0, tx_done = 1'b0, abort = 1'b0, raw_mode = 1'b0;
    logic [1:0] dump_chan = '0;
    logic [11:0] offset = '0;
    logic [7:0] gain = '0;
    logic [3:0] trace_end = '0;
    logic [23:0] rdata8;
    logic [35:0] rdata12;
    logic [7:0] mem8 [3][16];
    logic [11:0] mem12 [3][16];
    logic en8, trmt8, busy8, done8, err8, en12, trmt12, busy12, done12, err12;
    logic [3:0] addr8, addr12;
    logic [7:0] txd8, txd12;
    logic en_m, trmt_m, busy_m, done_m, err_m;
    logic [3:0] addr_m;
    logic [7:0] txd_m;
    int total = 0, bad = 0;

    trace_dump_engine #(.NUM_CH(3), .DATA_W(8), .ADDR_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req & ~sel), .dump_chan(dump_chan),
        .raw_mode(raw_mode), .offset(offset[7:0]), .gain(gain), .trace_end(trace_end),
        .abort(abort), .ram_en(en8), .ram_addr(addr8), .ram_rdata(rdata8), .tx_data(txd8),
        .trmt(trmt8), .tx_done(tx_done & ~sel), .busy(busy8), .dump_done(done8), .err(err8));

    trace_dump_engine #(.NUM_CH(3), .DATA_W(12), .ADDR_W(4)) u12 (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req & sel), .dump_chan(dump_chan),
        .raw_mode(raw_mode), .offset(offset), .gain(gain), .trace_end(trace_end),
        .abort(abort), .ram_en(en12), .ram_addr(addr12), .ram_rdata(rdata12), .tx_data(txd12),
        .trmt(trmt12), .tx_done(tx_done & sel), .busy(busy12), .dump_done(done12), .err(err12));

    assign {en_m, addr_m, txd_m, trmt_m, busy_m, done_m, err_m} = sel ?
        {en12, addr12, txd12, trmt12, busy12, done12, err12} :
        {en8, addr8, txd8, trmt8, busy8, done8, err8};

    always @(posedge clk) begin
        if (en8) for (int c = 0; c < 3; c++) rdata8[c*8 +: 8] <= mem8[c][addr8];
        if (en12) for (int c = 0; c < 3; c++) rdata12[c*12 +: 12] <= mem12[c][addr12];
    end

    function automatic int corr(input int rd, input int off, input int g, input bit raw, input int dw);
        int mx, s;
        mx = (1 << dw) - 1;
        s = rd + (off >= (1 << (dw - 1)) ? off - (1 << dw) : off);
        if (raw) return rd;
        s = s < 0 ? 0 : s > mx ? mx : s;
        s = s * g / 128;
        return s > mx ? mx : s;
    endfunction

    task automatic fill_random();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 16; a++) begin
                mem8[c][a] = 8'($urandom);
                mem12[c][a] = 12'($urandom);
            end
    endtask

    task automatic dump(input bit w, input int ch, input bit raw, input int off, input int g,
                        input int te, input int gap, input int abort_at, input bit inject, input bit spur);
        int nb, dw, n, smp, a, exp_b;
        bit inj, flag;
        nb = w ? 2 : 1;
        dw = w ? 12 : 8;
        sel = w;
        dump_chan = 2'(ch);
        raw_mode = raw;
        offset = 12'(off);
        gain = 8'(g);
        trace_end = 4'(te);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        total++;
        if (!(busy_m === 1'b1 && en_m === 1'b1 && addr_m === 4'(te + 1))) begin
            bad++;
            $display("FAIL start: busy=%0b ram_en=%0b ram_addr=%0d, need 1 1 %0d", busy_m, en_m, addr_m, (te + 1) % 16);
        end
        for (int s = 0; s < 16; s++) begin
            a = (te + 1 + s) % 16;
            smp = corr(w ? int'(mem12[ch][a]) : int'(mem8[ch][a]), off, g, raw, dw);
            for (int b = 0; b < nb; b++) begin
                n = 0;
                while (trmt_m !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                total++;
                if (n != (b == 0 ? 2 : 0)) begin
                    bad++;
                    $display("FAIL trmt latency s=%0d b=%0d: got %0d cycles, need %0d", s, b, n, b == 0 ? 2 : 0);
                end
                if (trmt_m !== 1'b1) return;
                exp_b = (nb == 2 && b == 0) ? smp >> 8 : smp & 255;
                total++;
                if (txd_m !== 8'(exp_b)) begin
                    bad++;
                    $display("FAIL tx_data s=%0d b=%0d addr=%0d: got %02h, need %02h", s, b, a, txd_m, exp_b);
                end
                if (s == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    total++;
                    if (busy_m !== 1'b0 || done_m !== 1'b0 || trmt_m !== 1'b0) begin
                        bad++;
                        $display("FAIL abort: busy=%0b dump_done=%0b trmt=%0b, need 0 0 0", busy_m, done_m, trmt_m);
                    end
                    flag = 1'b0;
                    repeat (30) begin
                        @(negedge clk);
                        if (trmt_m || done_m || busy_m) flag = 1'b1;
                    end
                    total++;
                    if (flag) begin
                        bad++;
                        $display("FAIL after abort: activity seen=%0b, need 0", flag);
                    end
                    return;
                end
                inj = inject && b == 0 && (s == 5 || s == 6);
                if (spur) tx_done = 1'b1;
                if (inj) begin
                    dump_req = 1'b1;
                    dump_chan = s == 5 ? 2'd0 : 2'd3;
                end
                @(negedge clk);
                tx_done = 1'b0;
                dump_req = 1'b0;
                if (inj) begin
                    total++;
                    if (err_m !== 1'b0) begin
                        bad++;
                        $display("FAIL err while busy: got %0b, need 0", err_m);
                    end
                end
                repeat (gap - 1) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                if (s == 15 && b == nb - 1) begin
                    total++;
                    if (done_m !== 1'b1 || busy_m !== 1'b0) begin
                        bad++;
                        $display("FAIL dump end: dump_done=%0b busy=%0b, need 1 0", done_m, busy_m);
                    end
                    @(negedge clk);
                    total++;
                    if (done_m !== 1'b0 || busy_m !== 1'b0) begin
                        bad++;
                        $display("FAIL dump_done pulse: dump_done=%0b busy=%0b, need 0 0", done_m, busy_m);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #0;
            total++;
            if ({en_m, addr_m, txd_m, trmt_m, busy_m, done_m, err_m} !== 17'd0) begin
                bad++;
                $display("FAIL %s dut%0d: outputs=%05h, need 00000", tag, k, {en_m, addr_m, txd_m, trmt_m, busy_m, done_m, err_m});
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");
    endtask

    task automatic test_sequence();
        for (int a = 0; a < 16; a++) mem8[1][a] = 8'(a * 17);
        dump(0, 1, 0, 0, 8'h80, 5, 2, -1, 1, 1);
    endtask

    task automatic test_saturation();
        logic [7:0] pat [4];
        pat = '{8'hF0, 8'h10, 8'h40, 8'hC0};
        for (int a = 0; a < 16; a++) mem8[2][a] = pat[a % 4];
        dump(0, 2, 0, 8'h20, 8'h80, 3, 1, -1, 0, 0);
        dump(0, 2, 0, 8'hE0, 8'h80, 9, 1, -1, 0, 0);
        dump(0, 2, 0, 0, 8'hFF, 15, 1, -1, 0, 0);
        dump(0, 2, 1, 8'h20, 8'hFF, 0, 1, -1, 0, 0);
    endtask

    task automatic test_wide();
        for (int a = 0; a < 16; a++) mem12[0][a] = a == 7 ? 12'hABC : 12'($urandom);
        dump(1, 0, 0, 0, 8'h80, 6, 2, -1, 0, 0);
        for (int a = 0; a < 16; a++) mem12[0][a] = 12'hABC;
        dump(1, 0, 0, 12'h7FF, 8'h80, 2, 2, -1, 0, 1);
    endtask

    task automatic test_abort();
        dump(0, 1, 0, 0, 8'h80, 5, 2, 2, 0, 0);
        dump(0, 1, 0, 0, 8'h80, 5, 1, -1, 0, 0);
    endtask

    task automatic test_err();
        sel = 1'b0;
        dump_chan = 2'd3;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        total++;
        if (err_m !== 1'b1 || busy_m !== 1'b0 || en_m !== 1'b0) begin
            bad++;
            $display("FAIL err pulse: err=%0b busy=%0b ram_en=%0b, need 1 0 0", err_m, busy_m, en_m);
        end
        @(negedge clk);
        total++;
        if (err_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL err one-shot: err=%0b busy=%0b, need 0 0", err_m, busy_m);
        end
    endtask

    task automatic test_reset_midwait();
        int n;
        sel = 1'b0;
        dump_chan = 2'd0;
        raw_mode = 1'b0;
        gain = 8'h80;
        offset = '0;
        trace_end = 4'd9;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        n = 0;
        while (trmt_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        dump(0, 0, 0, 8'h05, 8'h90, 9, 1, -1, 0, 0);
    endtask

    task automatic test_random();
        bit w;
        for (int i = 0; i < 6; i++) begin
            fill_random();
            w = 1'($urandom_range(0, 1));
            dump(w, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, w ? 4095 : 255),
                 $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(1, 3), -1, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        fill_random();
        test_reset();
        test_sequence();
        test_saturation();
        test_wide();
        test_abort();
        test_err();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_dump_engine.md
# trace_dump_engine

Parametrised trace read-out engine for the oscilloscope capture RAMs. It is the multi-channel, variable-width successor to the single-width dump path. On request it walks one channel's circular capture buffer oldest-to-newest. Each sample gets optional offset/gain correction with saturation, then goes out as one or more bytes over the UART transmit handshake. It sits between the capture RAM bank, the command handler and the UART transmitter.

## Interface
- NUM_CH, 3: number of capture channels (2..8); CH_W = clog2(NUM_CH)
- DATA_W, 8: sample width in bits (8..16); BYTES = ceil(DATA_W/8)
- ADDR_W, 9: RAM address width; DEPTH = 2^ADDR_W

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dump_req  in  1  one-cycle start pulse
- dump_chan  in  CH_W  channel to dump, sampled with dump_req
- raw_mode  in  1  1 = bypass correction, sampled with dump_req
- offset  in  DATA_W  signed two's-complement offset, sampled with dump_req
- gain  in  8  unsigned 1.7 fixed-point gain (0x80 = unity), sampled with dump_req
- trace_end  in  ADDR_W  address of newest sample, sampled with dump_req
- abort  in  1  cancel dump in progress
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM read address
- ram_rdata  in  NUM_CH*DATA_W  all channels' read data, channel c at [c*DATA_W +: DATA_W], valid one cycle after ram_en
- tx_data  out  8  byte to transmit
- trmt  out  1  one-cycle transmit strobe
- tx_done  in  1  one-cycle pulse, transmitter finished byte
- busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after final byte's tx_done
- err  out  1  one-cycle pulse when dump_req is rejected

## Operation
- States: IDLE, RD, CAP, SEND, WAIT.
- IDLE:
  - A dump_req with dump_chan < NUM_CH latches chan/raw_mode/offset/gain/trace_end, loads addr = trace_end+1 (mod DEPTH), clears the sample count, sets busy, and moves to RD.
  - A dump_req with dump_chan >= NUM_CH pulses err and stays in IDLE.
- RD: ram_en=1, ram_addr=addr; go to CAP.
- CAP: select channel slice of ram_rdata, compute the corrected sample, register it into the shift register; byte index = BYTES-1; go to SEND.
- SEND: trmt=1 for one cycle, tx_data = current byte (MSB byte first, sample zero-extended to BYTES*8); go to WAIT.
- WAIT: on tx_done:
  - If byte index > 0: decrement it and go to SEND.
  - Else if sample count == DEPTH-1: pulse dump_done, clear busy, go to IDLE.
  - Else: increment addr (wraps DEPTH-1 -> 0) and count, go to RD.
- One dump sends exactly DEPTH samples, from trace_end+1 to trace_end inclusive.
- Correction, with raw_mode=0:
  - sum = rdata + sext(offset), computed signed in DATA_W+2 bits.
  - sat_sum is sum clamped to [0, 2^DATA_W-1].
  - prod = sat_sum*gain in DATA_W+8 bits.
  - res = prod>>7, clamped to 2^DATA_W-1.
- raw_mode=1: res = rdata.
- dump_req while busy is ignored, with no err pulse.
- abort (any non-IDLE state) → IDLE next cycle, busy cleared, no dump_done, and trmt is not issued that cycle. An abort in IDLE has no effect. abort wins over a simultaneous tx_done.
- tx_done outside WAIT is ignored.

## Timing
- Reset: state IDLE. ram_en, ram_addr, tx_data, trmt, busy, dump_done and err are all 0. Internal addr, count and shift register are 0.
- dump_req accepted at edge 0: busy=1 and ram_en=1 from cycle 1, CAP in cycle 2, trmt=1 in cycle 3.
- tx_data is stable from the trmt cycle until the next trmt; ram_addr holds its value outside RD.
- Per-sample overhead: after the last tx_done of a sample, the next trmt follows 3 cycles later (RD, CAP, SEND).
- Between bytes of one sample, trmt follows tx_done by 1 cycle.
- dump_done is registered and fires in the cycle after the final tx_done; busy falls in that same cycle.
- A tx_done in the same cycle as trmt is not counted; WAIT begins the cycle after SEND.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- NUM_CH=3, DATA_W=8, ADDR_W=4, trace_end=5, chan=1, gain=0x80, offset=0, RAM ch1[a]=a*0x11, tx_done 2 cycles after each trmt → 16 bytes 0x66,0x77,…,0xFF,0x00,…,0x55. Addresses 6..15 then 0..5. dump_done one cycle after 16th tx_done; busy then low.
- Saturation, DATA_W=8:
  - rdata 0xF0, offset 0x20, gain 0x80 → 0xFF.
  - rdata 0x10, offset 0xE0 (−32) → 0x00.
  - rdata 0x40, gain 0xFF → 0x7F.
  - rdata 0xC0, gain 0xFF → 0xFF.
  - Repeat with raw_mode=1 → 0xF0, 0x10, 0x40, 0xC0.
- DATA_W=12, BYTES=2: sample 0xABC, gain 0x80, offset 0 → trmt with 0x0A, then trmt with 0xBC one cycle after first tx_done. offset 0x7FF on 0xABC → 0x0F, 0xFF.
- Abort after 3rd sample's trmt → busy low next cycle, no dump_done, no further trmt. A new dump_req afterwards restarts from trace_end+1.
- dump_chan=3 with NUM_CH=3 → err pulse, busy stays 0. dump_req mid-dump → ignored, sequence unchanged.
- Assert rst_n low mid-WAIT → all outputs 0 immediately. After release, engine idle and accepts a fresh dump_req.
